// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the core data-memory responder.
package mem_resp_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [2:0] {
        SZ_B  = 3'd0,
        SZ_H  = 3'd1,
        SZ_W  = 3'd2,
        SZ_BU = 3'd4,
        SZ_HU = 3'd5
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Unsigned loads have no store counterpart; codes 3/6/7 are unassigned.
    function automatic logic size_illegal(input logic [2:0] size, input logic we);
        logic bad;
        case (size)
            SZ_B, SZ_H, SZ_W: bad = 1'b0;
            SZ_BU, SZ_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication/byte enables and load extract/extend.
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [2:0]        size_i,
    input  logic              we_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [DATA_W-1:0] mem_rd_i,
    output logic [BE_W-1:0]   be_c,
    output logic [DATA_W-1:0] wd_c,
    output logic [DATA_W-1:0] rd_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem_rd_i[{addr_lo_i, 3'b000} +: 8];
        half_v = addr_lo_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        be_c   = '0;
        wd_c   = '0;
        rd_c   = '0;
        if (we_i) begin
            case (size_i)
                SZ_B: begin
                    be_c = BE_W'(4'b0001 << addr_lo_i);
                    wd_c = {4{wd_i[7:0]}};
                end
                SZ_H: begin
                    be_c = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                    wd_c = {2{wd_i[15:0]}};
                end
                SZ_W: begin
                    be_c = 4'b1111;
                    wd_c = wd_i;
                end
                default: begin
                    be_c = '0;
                    wd_c = '0;
                end
            endcase
        end else begin
            // Loads always fetch the full word; the lane is picked on return.
            be_c = '1;
            case (size_i)
                SZ_B:    rd_c = {{24{byte_v[7]}}, byte_v};
                SZ_BU:   rd_c = {24'd0, byte_v};
                SZ_H:    rd_c = {{16{half_v[15]}}, half_v};
                SZ_HU:   rd_c = {16'd0, half_v};
                SZ_W:    rd_c = mem_rd_i;
                default: rd_c = '0;
            endcase
        end
    end

endmodule

// File: rtl/core_mem_responder.sv
// Core data-port responder: one load/store at a time onto a ready-handshake bus.
// Optional alignment checking is enabled by defining MEM_MISALIGN_CHECK_EN.
module core_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [2:0]        core_size_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wd_i,
    output logic [DATA_W-1:0] core_rd_o,
    output logic              core_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wd_o,
    input  logic [DATA_W-1:0] mem_rd_i,
    input  logic              mem_ready_i,
    output logic              err_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              err_q, err_d;

    logic              illegal_c;
    logic              misalign_c;
    logic              reject_c;
    logic              in_wait_c;
    logic [BE_W-1:0]   lane_be_c;
    logic [DATA_W-1:0] lane_wd_c;
    logic [DATA_W-1:0] lane_rd_c;

    mem_lane_align u_lane (
        .size_i    (core_size_i),
        .we_i      (core_we_i),
        .addr_lo_i (core_addr_i[1:0]),
        .wd_i      (core_wd_i),
        .mem_rd_i  (mem_rd_i),
        .be_c      (lane_be_c),
        .wd_c      (lane_wd_c),
        .rd_c      (lane_rd_c)
    );

    assign illegal_c = size_illegal(core_size_i, core_we_i);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_c = (((core_size_i == SZ_H) || (core_size_i == SZ_HU)) && core_addr_i[0])
                      || ((core_size_i == SZ_W) && (core_addr_i[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    assign reject_c  = illegal_c | misalign_c;
    assign in_wait_c = (state_q == ST_WAIT);

    // Bus side follows the live core request, exposed only while waiting.
    assign mem_req_o    = in_wait_c;
    assign mem_we_o     = in_wait_c & core_we_i;
    assign mem_be_o     = in_wait_c ? lane_be_c : '0;
    assign mem_addr_o   = in_wait_c ? {core_addr_i[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wd_o     = in_wait_c ? lane_wd_c : '0;
    assign core_stall_o = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && core_req_i);
    assign core_rd_o    = rd_q;
    assign err_o        = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (core_req_i) begin
                    cnt_d = '0;
                    if (reject_c) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rd_d    = '0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_ready_i) begin
                    state_d = ST_DONE;
                    if (!core_we_i) begin
                        rd_d = lane_rd_c;
                    end
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q != CNT_MAX)) begin
                    // Abort in the WAIT cycle where the count reaches the limit.
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_MAX) begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                        rd_d    = '0;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_core_mem_responder.sv
// Self-checking bench for core_mem_responder: directed cases plus random accesses
// against a behavioural model; honours MEM_MISALIGN_CHECK_EN when defined.
module tb_core_mem_responder;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;
    logic        err_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_rd = 32'd0;

    core_mem_responder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load result from the addressed lane, sign- or zero-extended.
    function automatic logic [31:0] ref_load(input logic [2:0] sz, input logic [1:0] a,
                                             input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (sz)
            3'd0:    return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
            3'd2:    return w;
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_st_be(input logic [2:0] sz, input logic [1:0] a);
        case (sz)
            3'd0:    return 32'(1) << a;
            3'd1:    return a[1] ? 32'hC : 32'h3;
            3'd2:    return 32'hF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_st_wd(input logic [2:0] sz, input logic [31:0] w);
        case (sz)
            3'd0:    return w[7:0] * 32'h0101_0101;
            3'd1:    return w[15:0] * 32'h0001_0001;
            3'd2:    return w;
            default: return 32'h0;
        endcase
    endfunction

    // One complete access; ready_at = WAIT cycle (1-based) carrying mem_ready, 0 = never.
    task automatic run_access(input string nm, input logic we, input logic [2:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int ready_at, input logic [31:0] mrd);
        logic        illegal, misal, bad, tmo;
        int          exp_waits, waits, stalls;
        logic [31:0] exp_rd;
        bit          done;
        illegal = (sz == 3'd3) || (sz >= 3'd6) || (((sz == 3'd4) || (sz == 3'd5)) && we);
        misal   = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        misal = (((sz == 3'd1) || (sz == 3'd5)) && addr[0]) || ((sz == 3'd2) && (addr[1:0] != 2'b00));
`endif
        bad       = illegal | misal;
        tmo       = !bad && ((ready_at < 1) || (ready_at > int'(TO)));
        exp_waits = bad ? 0 : (tmo ? int'(TO) : ready_at);
        exp_rd    = (bad || tmo) ? 32'd0 : (we ? model_rd : ref_load(sz, addr[1:0], mrd));
        waits  = 0;
        stalls = 0;
        done   = 0;

        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = sz;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'b0;
        #1;
        chk($sformatf("%s.idle_stall", nm), 32'(core_stall_o), 32'd1);
        chk($sformatf("%s.idle_memreq", nm), 32'(mem_req_o), 32'd0);
        stalls = 1;

        for (int c = 1; c <= int'(TO) + 3 && !done; c++) begin
            @(posedge clk_i); #1;
            mem_ready_i = (c == ready_at);
            mem_rd_i    = (c == ready_at) ? mrd : $urandom;
            #1;
            if (!core_stall_o) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_req_o) waits++;
                if (c == 1 && !bad) begin
                    chk($sformatf("%s.we", nm), 32'(mem_we_o), 32'(we));
                    chk($sformatf("%s.addr", nm), mem_addr_o, {addr[31:2], 2'b00});
                    chk($sformatf("%s.be", nm), 32'(mem_be_o), we ? ref_st_be(sz, addr[1:0]) : 32'hF);
                    if (we) chk($sformatf("%s.wd", nm), mem_wd_o, ref_st_wd(sz, wd));
                end
            end
        end
        chk($sformatf("%s.stall_fell", nm), 32'(done), 32'd1);
        chk($sformatf("%s.waits", nm), 32'(waits), 32'(exp_waits));
        chk($sformatf("%s.stall_cycles", nm), 32'(stalls), 32'(1 + exp_waits));
        chk($sformatf("%s.err", nm), 32'(err_o), 32'(bad | tmo));
        chk($sformatf("%s.rd", nm), core_rd_o, exp_rd);
        chk($sformatf("%s.done_memreq", nm), 32'(mem_req_o), 32'd0);
        model_rd = exp_rd;

        @(posedge clk_i); #1;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
        #1;
        chk($sformatf("%s.err_pulse_end", nm), 32'(err_o), 32'd0);
        chk($sformatf("%s.rd_hold", nm), core_rd_o, exp_rd);
        chk($sformatf("%s.idle_no_stall", nm), 32'(core_stall_o), 32'd0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'd0;
        core_wd_i   = 32'd0;
        mem_rd_i    = 32'd0;
        mem_ready_i = 1'b0;
        #12;
        chk("reset.rd", core_rd_o, 32'd0);
        chk("reset.memreq", 32'(mem_req_o), 32'd0);
        chk("reset.we", 32'(mem_we_o), 32'd0);
        chk("reset.be", 32'(mem_be_o), 32'd0);
        chk("reset.err", 32'(err_o), 32'd0);
        chk("reset.stall", 32'(core_stall_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_access("lw",    1'b0, 3'd2, 32'h100, 32'd0, 1, 32'hDEAD_BEEF);
        chk("lw.value", core_rd_o, 32'hDEAD_BEEF);
        run_access("lb",    1'b0, 3'd0, 32'h103, 32'd0, 1, 32'h80FF_0000);
        chk("lb.value", core_rd_o, 32'hFFFF_FF80);
        run_access("lbu",   1'b0, 3'd4, 32'h103, 32'd0, 2, 32'h80FF_0000);
        chk("lbu.value", core_rd_o, 32'h0000_0080);
        run_access("lh",    1'b0, 3'd1, 32'h102, 32'd0, 1, 32'h8001_1234);
        chk("lh.value", core_rd_o, 32'hFFFF_8001);
        run_access("lhu",   1'b0, 3'd5, 32'h102, 32'd0, 3, 32'h8001_1234);
        chk("lhu.value", core_rd_o, 32'h0000_8001);
        run_access("sb",    1'b1, 3'd0, 32'h201, 32'h0000_00AB, 1, 32'd0);
        run_access("sh",    1'b1, 3'd1, 32'h202, 32'h0000_1234, 2, 32'd0);
        run_access("sw",    1'b1, 3'd2, 32'h204, 32'hCAFE_F00D, int'(TO), 32'd0);
        run_access("lw_tmo", 1'b0, 3'd2, 32'h104, 32'd0, 0, 32'h1111_1111);
        run_access("lw_late", 1'b0, 3'd2, 32'h108, 32'd0, int'(TO) + 1, 32'h2222_2222);
        run_access("lw_odd", 1'b0, 3'd2, 32'h102, 32'd0, 1, 32'h3333_4444);
        run_access("ill3",  1'b0, 3'd3, 32'h110, 32'd0, 1, 32'h5555_5555);
        run_access("sbu",   1'b1, 3'd4, 32'h111, 32'h77, 1, 32'd0);

        // mem_ready while idle must not disturb anything.
        @(posedge clk_i); #1;
        mem_ready_i = 1'b1;
        #1;
        chk("idle_ready.stall", 32'(core_stall_o), 32'd0);
        chk("idle_ready.memreq", 32'(mem_req_o), 32'd0);
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0;
        #1;
        chk("idle_ready.err", 32'(err_o), 32'd0);
        run_access("after_idle_ready", 1'b0, 3'd2, 32'h120, 32'd0, 2, 32'h0BAD_F00D);

        // Asynchronous reset while waiting.
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h300;
        @(posedge clk_i); #2;
        chk("rst_wait.memreq_before", 32'(mem_req_o), 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("rst_wait.memreq", 32'(mem_req_o), 32'd0);
        chk("rst_wait.be", 32'(mem_be_o), 32'd0);
        chk("rst_wait.we", 32'(mem_we_o), 32'd0);
        chk("rst_wait.rd", core_rd_o, 32'd0);
        chk("rst_wait.err", 32'(err_o), 32'd0);
        core_req_i = 1'b0;
        model_rd   = 32'd0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_access("post_reset", 1'b0, 3'd1, 32'h302, 32'd0, 1, 32'hFEDC_7654);

        for (int i = 0; i < 250; i++) begin
            run_access($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), $urandom, $urandom,
                       int'($urandom_range(0, TO + 1)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
